// File: rtl/ps2_hex_entry.sv
// PS/2 keyboard hex-entry: pin filtering, frame receive, set-2 decode into a nibble entry register.
// Optional backspace (make 0x66) support when PS2_HEX_BACKSPACE_EN is defined.
module ps2_hex_entry #(
  parameter int DIGITS         = 8,
  parameter int FILTER_LEN     = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                         i_clk100mhz,
  input  logic                         i_rst_n,
  input  logic                         i_ps2_clk,
  input  logic                         i_ps2_dat,
  output logic [4*DIGITS-1:0]          o_entry,
  output logic [$clog2(DIGITS+1)-1:0]  o_digit_count,
  output logic [4*DIGITS-1:0]          o_committed,
  output logic                         o_commit,
  output logic                         o_frame_err,
  output logic                         o_overflow
);
  // state    | meaning
  // S_IDLE   | waiting for a start bit (data low on a clock fall)
  // S_DATA   | shifting 8 data bits, LSB first
  // S_PARITY | capturing the odd-parity bit
  // S_STOP   | checking stop bit and parity, then releasing the byte
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int EW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DIGITS);
  localparam logic [TW-1:0] TO_LOAD    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    FLT_LOAD   = 4'(FILTER_LEN - 1);

  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic r_clk_filt, r_fall;
  logic [3:0] r_filt_cnt;

  state_t r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift, r_byte;
  logic r_parity, r_byte_valid, r_frame_err;
  logic [TW-1:0] r_to_cnt;

  logic r_ext, r_brk, r_commit, r_overflow;
  logic [EW-1:0] r_entry, r_committed;
  logic [CW-1:0] r_count;
  logic [4:0] w_hex;

  always_ff @(posedge i_clk100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Down-counter reloads whenever the sample matches the accepted level.
  always_ff @(posedge i_clk100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= FLT_LOAD;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= FLT_LOAD;
      end else if (r_filt_cnt == 4'd0) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= FLT_LOAD;
        r_fall     <= ~r_clk_s2;
      end else begin
        r_filt_cnt <= r_filt_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_parity     <= 1'b0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_to_cnt     <= TO_LOAD;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state == S_IDLE || r_fall)
        r_to_cnt <= TO_LOAD;
      else if (r_to_cnt != '0)
        r_to_cnt <= r_to_cnt - 1'b1;

      if (r_state != S_IDLE && !r_fall && r_to_cnt == '0) begin
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
      end else if (r_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            if (r_dat_s2 && (^{r_shift, r_parity})) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // {hit, nibble} for set-2 make codes of keys 0..F
  always_comb begin
    w_hex = 5'd0;
    case (r_byte)
      8'h45: w_hex = 5'h10;
      8'h16: w_hex = 5'h11;
      8'h1E: w_hex = 5'h12;
      8'h26: w_hex = 5'h13;
      8'h25: w_hex = 5'h14;
      8'h2E: w_hex = 5'h15;
      8'h36: w_hex = 5'h16;
      8'h3D: w_hex = 5'h17;
      8'h3E: w_hex = 5'h18;
      8'h46: w_hex = 5'h19;
      8'h1C: w_hex = 5'h1A;
      8'h32: w_hex = 5'h1B;
      8'h21: w_hex = 5'h1C;
      8'h23: w_hex = 5'h1D;
      8'h24: w_hex = 5'h1E;
      8'h2B: w_hex = 5'h1F;
      default: w_hex = 5'd0;
    endcase
  end

  always_ff @(posedge i_clk100mhz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_entry     <= '0;
      r_count     <= '0;
      r_committed <= '0;
      r_commit    <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (r_byte_valid) begin
        if (r_byte == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (!r_brk) begin
            if (w_hex[4]) begin
              if (r_count < FULL_COUNT) begin
                r_entry <= (r_entry << 4) | EW'(w_hex[3:0]);
                r_count <= r_count + 1'b1;
              end else begin
                r_overflow <= 1'b1;
              end
            end else if (r_byte == 8'h5A) begin
              r_committed <= r_entry;
              r_commit    <= 1'b1;
              r_entry     <= '0;
              r_count     <= '0;
              r_overflow  <= 1'b0;
            end else if (r_byte == 8'h76) begin
              r_entry    <= '0;
              r_count    <= '0;
              r_overflow <= 1'b0;
            end
`ifdef PS2_HEX_BACKSPACE_EN
            else if (r_byte == 8'h66 && r_count != '0) begin
              r_entry    <= r_entry >> 4;
              r_count    <= r_count - 1'b1;
              r_overflow <= 1'b0;
            end
`endif
          end
        end
      end
    end
  end

  assign o_entry       = r_entry;
  assign o_digit_count = r_count;
  assign o_committed   = r_committed;
  assign o_commit      = r_commit;
  assign o_frame_err   = r_frame_err;
  assign o_overflow    = r_overflow;

endmodule
